// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam int unsigned DefMaxDataRun = 4;
  localparam int unsigned RunCntWidth   = $clog2(DefMaxDataRun + 1);

  // Width needed to hold 0..max_run; never narrower than one bit.
  function automatic int unsigned run_cnt_width(input int unsigned max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  // Fetch requester
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;

  // Load/store requester
  logic                  d_req_i;
  logic                  d_we_i;
  logic                  d_byte_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;

  // External memory
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic                  mem_byte_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ready_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  stall_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_req_i, d_we_i, d_byte_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_byte_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i,
    output stall_o
  );

  // Core and memory side
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_req_i, d_we_i, d_byte_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_byte_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i,
    input  stall_o
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and data, plus the saturating data-run counter
// that keeps a stream of data accesses from starving instruction fetch.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = DefMaxDataRun,
  parameter int unsigned CntW         = RunCntWidth
) (
  input  logic            arb_en_i,   // arbiter idle and out of reset
  input  logic            if_req_i,
  input  logic            d_req_i,
  input  logic [CntW-1:0] run_cnt_i,
  output logic [1:0]      gnt_o,      // bit 0 fetch, bit 1 data
  output logic [CntW-1:0] run_cnt_o
);

  localparam logic [CntW-1:0] RunMax = CntW'(MAX_DATA_RUN);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // Data wins ties until it has used up its run, then fetch gets one slot.
  always_comb begin
    gnt_o     = 2'b00;
    run_cnt_o = run_cnt_i;
    if (arb_en_i) begin
      if (d_req_i && (!if_req_i || (run_cnt_i != RunMax))) begin
        gnt_o[1] = 1'b1;
      end else if (if_req_i) begin
        gnt_o[0] = 1'b1;
      end
      if (gnt_o[1]) begin
        run_cnt_o = (run_cnt_i == RunMax) ? run_cnt_i : run_cnt_i + CntOne;
      end else begin
        // Fetch grant or an idle cycle with nothing pending
        run_cnt_o = '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// sequencing a variable-latency request/ready handshake.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_DATA_RUN = DefMaxDataRun
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = run_cnt_width(MAX_DATA_RUN);

  arb_state_t            state_q;
  owner_t                owner_q;
  logic [CntW-1:0]       run_cnt_q, run_cnt_d;
  logic [1:0]            gnt;
  logic                  arb_en;

  logic                  mem_req_q, mem_we_q, mem_byte_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  if_rvalid_q, d_rvalid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, d_rdata_q;

  assign arb_en = (state_q == IDLE) && !rst;

  mem_arb_prio #(
    .MAX_DATA_RUN(MAX_DATA_RUN),
    .CntW        (CntW)
  ) u_prio (
    .arb_en_i (arb_en),
    .if_req_i (bus.if_req_i),
    .d_req_i  (bus.d_req_i),
    .run_cnt_i(run_cnt_q),
    .gnt_o    (gnt),
    .run_cnt_o(run_cnt_d)
  );

  // Access sequencer: latch the granted request onto the bus, wait for ready, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      run_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      run_cnt_q   <= run_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (gnt[1]) begin
            state_q     <= BUSY_D;
            owner_q     <= OWN_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we_i;
            mem_byte_q  <= bus.d_byte_i;
            mem_addr_q  <= bus.d_addr_i;
            mem_wdata_q <= bus.d_wdata_i;
          end else if (gnt[0]) begin
            state_q     <= BUSY_IF;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= bus.if_addr_i;
            mem_wdata_q <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (bus.mem_ready_i) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (owner_q == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata_i;
            end else begin
              d_rvalid_q <= 1'b1;
              // Stores leave the last load data visible
              if (!mem_we_q) d_rdata_q <= bus.mem_rdata_i;
            end
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grants and stall are combinational so the core sees them in the arbitration cycle.
  always_comb begin
    bus.if_gnt_o = gnt[0];
    bus.d_gnt_o  = gnt[1];
    bus.stall_o  = !rst && ((state_q != IDLE) || (bus.if_req_i && !gnt[0]) ||
                            (bus.d_req_i && !gnt[1]));
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_byte_o  = mem_byte_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.d_rvalid_o  = d_rvalid_q;
  assign bus.d_rdata_o   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of the core.
- Grants one requester at a time and sequences the external memory handshake, which has variable latency.
- Returns read data or write acknowledgement to the granted requester.
- Drives a core stall signal while any access is outstanding or any request is waiting.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, memory data width
MAX_DATA_RUN, 4, max consecutive data grants while fetch waits (anti-starvation)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
if_req_i  input  1  fetch request; held until if_gnt_o
if_addr_i  input  ADDR_WIDTH  fetch address
if_gnt_o  output  1  fetch granted this cycle
if_rvalid_o  output  1  one-cycle pulse, if_rdata_o valid
if_rdata_o  output  DATA_WIDTH  fetched instruction
d_req_i  input  1  data request; held until d_gnt_o
d_we_i  input  1  1=store, 0=load
d_byte_i  input  1  byte access (ByteOp)
d_addr_i  input  ADDR_WIDTH  data address
d_wdata_i  input  DATA_WIDTH  store data
d_gnt_o  output  1  data granted this cycle
d_rvalid_o  output  1  one-cycle pulse: load data valid or store done
d_rdata_o  output  DATA_WIDTH  load data
mem_req_o  output  1  memory request, held until mem_ready_i
mem_we_o  output  1  memory write
mem_byte_o  output  1  memory byte access
mem_addr_o  output  ADDR_WIDTH  memory address
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_ready_i  input  1  memory completes access this cycle
mem_rdata_i  input  DATA_WIDTH  memory read data, valid with mem_ready_i
stall_o  output  1  core must hold state

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE. Run counter is cleared.
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE, arbitration:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant data unless run_cnt == MAX_DATA_RUN; in that case grant fetch.
  - The grant (if_gnt_o / d_gnt_o) is combinational in the IDLE cycle; at most one is high.
  - On grant, register address, we, byte and wdata onto mem_*, then go to BUSY_IF or BUSY_D.
  - Fetch accesses always use mem_we_o=0 and mem_byte_o=0.
- Run counter:
  - Increments on each data grant, saturating at MAX_DATA_RUN.
  - Clears on each fetch grant.
  - Clears on any IDLE cycle with no request pending.
- BUSY_*:
  - mem_req_o=1 and all mem_* held stable until mem_ready_i=1.
  - On mem_ready_i, capture mem_rdata_i, then go to RESP.
  - mem_req_o drops in the cycle after ready.
- RESP: pulse the matching rvalid for exactly one cycle, then go to IDLE.
  - Load: d_rdata_o = captured data.
  - Store: d_rdata_o holds its previous value.
  - Fetch: if_rdata_o = captured data.
  - rdata outputs hold until the next response to the same requester.
- Latency: grant at cycle t, mem_req_o high from t+1; ready at t+1+k (k>=0); rvalid at t+2+k. Next grant is possible at t+3+k.
- mem_ready_i is ignored whenever mem_req_o=0.
- stall_o = (state != IDLE) | (if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o). It is combinational.
- Address low bits pass through unmodified; byte-lane steering belongs to memory.
- rst asserted mid-access: next cycle state=IDLE and mem_req_o=0. No rvalid is issued for the aborted access; a late mem_ready_i is ignored. Run counter is cleared.

Decomposition:
- Package mem_arb_pkg contains:
  - arb_state_t enum (IDLE, BUSY_IF, BUSY_D, RESP)
  - owner_t enum (OWN_IF, OWN_D)
  - localparam for counter width, $clog2(MAX_DATA_RUN+1)
- One sub-module, mem_arb_prio: combinational priority select plus the saturating run counter. Outputs the grant vector and the next counter value.

Test Plan:
- Single fetch 0x0000_0010, memory ready after 2 cycles, rdata 0x0051_0113 -> if_gnt_o at t, mem_req_o t+1..t+3, if_rvalid_o at t+4 with if_rdata_o=0x0051_0113.
- Store byte to 0x0000_0103, d_wdata_i 0xAB, ready at k=0 -> mem_we_o=1, mem_byte_o=1, mem_addr_o=0x103; d_rvalid_o pulses once; d_rdata_o unchanged.
- Both requests held continuously, MAX_DATA_RUN=4, ready at k=0 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Simultaneous first request in IDLE -> d_gnt_o=1, if_gnt_o=0; stall_o=1 until fetch rvalid.
- rst pulse while BUSY_D, with mem_ready_i asserted the following cycle -> mem_req_o=0 after reset; no d_rvalid_o; next request is granted normally.
- mem_ready_i asserted while idle -> no rvalid, no state change.
